i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: BCK_DIV, default 4, PCLK cycles per BCK half-period; legal range 2..255.
REQ-002 PCLK  input  1  sole clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 sample_l  input  16  left sample, two's complement.
REQ-005 sample_r  input  16  right sample, two's complement.
REQ-006 sample_valid  input  1  sample pair offered.
REQ-007 sample_ready  output  1  holding register empty; transfer when sample_valid & sample_ready on a PCLK edge.
REQ-008 mute  input  1  transmit zeros while high; sampled at frame load.
REQ-009 I2S_BCK  output  1  bit clock, 50% duty.
REQ-010 I2S_WS  output  1  word select: 0 = left, 1 = right.
REQ-011 I2S_DATA  output  1  serial data, MSB first.
REQ-012 underflow  output  1  one-PCLK pulse when a frame loads with the holding register empty.

Function
REQ-013 Divider div_cnt counts 0..BCK_DIV-1 and wraps. I2S_BCK toggles in the cycle where div_cnt == BCK_DIV-1.
REQ-014 Falling-edge event: the toggle cycle with I2S_BCK currently 1. I2S_WS, I2S_DATA and the slot counter update only in that cycle, so both outputs change together with BCK going low.
REQ-015 Slot counter s runs 0..31 and wraps 31->0 on each falling-edge event.
REQ-016 Frame register F[31:0] = {L[15:0], R[15:0]}. In slot s, I2S_DATA = F[31-s].
REQ-017 I2S_WS = 1 for s in 15..30 and 0 for s in {31, 0..14}. WS therefore leads the channel MSB by one BCK (Philips I2S).
REQ-018 Frame load happens on the falling-edge event entering s = 0:
- holding full, mute = 0: F <= holding, holding becomes empty.
- holding full, mute = 1: F <= 0, holding is still consumed.
- holding empty: F <= 0, underflow pulses in that cycle.
REQ-019 sample_ready = ~holding_full, driven combinationally from the register state.
REQ-020 On accept, holding <= {sample_l, sample_r} and holding_full <= 1.
REQ-021 Accept and frame load in the same cycle: a load from an empty holding register uses zeros and pulses underflow, and the accepted pair is captured into holding for the next frame. No sample is lost or duplicated.
REQ-022 Latency: a pair accepted into empty holding during frame k appears on I2S_DATA starting at slot 0 of frame k+1.
REQ-023 One frame lasts 64*BCK_DIV PCLK cycles.
REQ-024 sample_valid with sample_ready = 0 has no effect, and the source holds its data.

Reset
REQ-025 While reset_n = 0:
- I2S_BCK = 0, I2S_WS = 0, I2S_DATA = 0, underflow = 0.
- div_cnt = 0, s = 31, F = 0, holding empty, sample_ready = 1.
REQ-026 Reset asserted mid-frame takes effect immediately, even with no PCLK edge, and discards holding and F.
REQ-027 After release, the first falling-edge event occurs 2*BCK_DIV cycles later and enters s = 0 with a frame load.

Structure
REQ-028 A shared package holds:
- SAMPLE_W = 16, SLOTS = 32.
- The frame type (32-bit vector).
- The WS slot bounds (15, 30).
REQ-029 One sub-module, i2s_bck_gen, contains div_cnt and BCK and outputs a one-cycle fall_evt strobe. The top level contains the slot counter, the holding register and the frame register.

Verification
REQ-030 Directed scenarios:
- Reset release, no samples, BCK_DIV = 4 -> BCK period 8 PCLK; underflow every 256 PCLK; DATA constant 0; WS 0 for slots 31 and 0..14.
- Accept L = 0x8001, R = 0x7FFE in frame 0 -> frame 1 DATA = 1000_0000_0000_0001 then 0111_1111_1111_1110, MSB-first; WS rises one BCK before the R MSB; no underflow at frame 1.
- Two back-to-back valid pairs -> second held off (ready = 0) until the frame-1 load; both transmitted in order in frames 1 and 2.
- Valid asserted exactly on the load cycle with holding empty -> underflow = 1 in that cycle; the pair is transmitted in the next frame.
- mute = 1 at load with holding full (0x1234/0x5678) -> frame all zeros; ready returns to 1; no underflow.
- reset_n pulsed low mid-frame in slot 20 -> outputs immediately 0, ready = 1; after release, first fall at 2*BCK_DIV cycles, slot 0.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// I2S transmitter shared types and constants.
// Frame layout, slot count and word-select window.
package i2s_tx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SLOTS    = 32;
  localparam int SLOT_W   = $clog2(SLOTS);

  typedef logic [2*SAMPLE_W-1:0] frame_t;

  localparam logic [SLOT_W-1:0] WS_LO = 5'd15;
  localparam logic [SLOT_W-1:0] WS_HI = 5'd30;

  function automatic logic ws_for(
    input logic [SLOT_W-1:0] s
  );
    return (s >= WS_LO) && (s <= WS_HI);
  endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// I2S bit-clock divider: PCLK, reset_n in; bck_o (50% duty)
// and fall_evt_o (one-cycle strobe, BCK about to fall) out.
module i2s_bck_gen #(
  parameter int BCK_DIV = 4
) (
  input  logic PCLK,
  input  logic reset_n,
  output logic bck_o,
  output logic fall_evt_o
);

  localparam int CW = $clog2(BCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(BCK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bck_q, bck_d;
  logic          tgl;

  assign tgl = (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = tgl ? '0 : div_cnt_q + 1'b1;
    bck_d     = tgl ? ~bck_q : bck_q;
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      bck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bck_q     <= bck_d;
    end
  end

  assign bck_o      = bck_q;
  assign fall_evt_o = tgl & bck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) stereo transmitter, 16-bit samples, 32 slots.
// In: PCLK, reset_n, sample_l/r, sample_valid, mute.
// Out: sample_ready, I2S_BCK, I2S_WS, I2S_DATA, underflow.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int BCK_DIV = 4
) (
  input  logic                PCLK,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                mute,
  output logic                I2S_BCK,
  output logic                I2S_WS,
  output logic                I2S_DATA,
  output logic                underflow
);

  localparam logic [SLOT_W-1:0] S_LAST = SLOT_W'(SLOTS - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  frame_t            frame_q, frame_d;
  frame_t            hold_q, hold_d;
  logic              full_q, full_d;
  logic              ws_q, ws_d;
  logic              data_q, data_d;
  logic              fall, load, accept;

  i2s_bck_gen #(
    .BCK_DIV (BCK_DIV)
  ) u_bck (
    .PCLK       (PCLK),
    .reset_n    (reset_n),
    .bck_o      (I2S_BCK),
    .fall_evt_o (fall)
  );

  assign load   = fall & (slot_q == S_LAST);
  assign accept = sample_valid & ~full_q;

  always_comb begin
    slot_d  = slot_q;
    frame_d = frame_q;
    hold_d  = hold_q;
    full_d  = full_q;
    ws_d    = ws_q;
    data_d  = data_q;
    if (load) begin
      frame_d = (full_q && !mute) ? hold_q : '0;
      full_d  = 1'b0;
    end
    // An accept on the load cycle only happens when empty,
    // so the new pair waits in holding for the next frame.
    if (accept) begin
      hold_d = {sample_l, sample_r};
      full_d = 1'b1;
    end
    if (fall) begin
      slot_d = slot_q + 1'b1;
      ws_d   = ws_for(slot_d);
      data_d = frame_d[S_LAST - slot_d];
    end
  end

  always_ff @(posedge PCLK or negedge reset_n) begin
    if (!reset_n) begin
      slot_q  <= S_LAST;
      frame_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      ws_q    <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      frame_q <= frame_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ws_q    <= ws_d;
      data_q  <= data_d;
    end
  end

  assign sample_ready = ~full_q;
  assign underflow    = load & ~full_q;
  assign I2S_WS       = ws_q;
  assign I2S_DATA     = data_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx (BCK_DIV = 4).
// Scoreboard of expected frames checked slot by slot.
module tb_i2s_tx;
  import i2s_tx_pkg::*;

  localparam int DIV    = 4;
  localparam int BCKP   = 2 * DIV;
  localparam int FRAMEP = 64 * DIV;

  logic        PCLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        mute = 1'b0;
  logic        sample_ready;
  logic        I2S_BCK;
  logic        I2S_WS;
  logic        I2S_DATA;
  logic        underflow;

  typedef struct {
    int          frame;
    logic [31:0] data;
    bit          uf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          last_fall = 0;
  int          frame_start = 0;
  int          frame_n = -1;
  logic [4:0]  slot_m = 5'd31;
  logic        bck_p = 1'b0;
  logic        uf_seen = 1'b0;
  logic [31:0] cur = '0;

  event frame_ev, s31_ev, s20_ev;

  i2s_tx #(
    .BCK_DIV (DIV)
  ) dut (
    .PCLK         (PCLK),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mute         (mute),
    .I2S_BCK      (I2S_BCK),
    .I2S_WS       (I2S_WS),
    .I2S_DATA     (I2S_DATA),
    .underflow    (underflow)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push_pair(
    input  logic [15:0] l,
    input  logic [15:0] r,
    output bit          ok
  );
    ok = 1'b0;
    sample_l = l;
    sample_r = r;
    sample_valid = 1'b1;
    for (int i = 0; i < 600 && !ok; i++) begin
      ok = sample_ready;
      @(posedge PCLK);
      #1;
    end
    sample_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge PCLK) begin
    if (!reset_n) begin
      cyc = 0;
      last_fall = 0;
      frame_start = 0;
      frame_n = -1;
      slot_m = 5'd31;
      bck_p = 1'b0;
      uf_seen = 1'b0;
      cur = '0;
    end else begin
      cyc++;
      if (underflow) uf_seen = 1'b1;
      if (bck_p && !I2S_BCK) begin
        check("bck_per", 32'(cyc - last_fall), 32'(BCKP));
        last_fall = cyc;
        slot_m = slot_m + 5'd1;
        if (slot_m == 5'd0) begin
          frame_n++;
          if (frame_n > 0)
            check("frame_per", 32'(cyc - frame_start),
                  32'(FRAMEP));
          frame_start = cyc;
          e = '{frame_n, 32'h0, 1'b1};
          if (exp_q.size() > 0 && exp_q[0].frame == frame_n)
            e = exp_q.pop_front();
          check("underflow", 32'(uf_seen), 32'(e.uf));
          uf_seen = 1'b0;
          cur = e.data;
          -> frame_ev;
        end
        check("data", 32'(I2S_DATA), 32'(cur[5'd31 - slot_m]));
        check("ws", 32'(I2S_WS),
              32'(slot_m >= 5'd15 && slot_m <= 5'd30));
        if (slot_m == 5'd31) -> s31_ev;
        if (slot_m == 5'd20) -> s20_ev;
      end
      bck_p = I2S_BCK;
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int k;
    repeat (2) @(negedge PCLK);
    #1;
    check("rst_bck", 32'(I2S_BCK), 32'd0);
    check("rst_ws", 32'(I2S_WS), 32'd0);
    check("rst_data", 32'(I2S_DATA), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    @(negedge PCLK);
    #1 reset_n = 1'b1;

    @(frame_ev);
    check("first_fall", 32'(cyc), 32'(BCKP));
    @(frame_ev);

    // single pair 0x8001 / 0x7FFE
    repeat (5) @(negedge PCLK);
    k = frame_n;
    push_pair(16'h8001, 16'h7FFE, ok);
    exp_q.push_back('{k + 1, 32'h8001_7FFE, 1'b0});
    @(frame_ev);

    // back-to-back pairs
    repeat (10) @(negedge PCLK);
    k = frame_n;
    push_pair(16'h00FF, 16'hA5A5, ok);
    exp_q.push_back('{k + 1, 32'h00FF_A5A5, 1'b0});
    check("ready_busy", 32'(sample_ready), 32'd0);
    push_pair(16'hC3C3, 16'h1001, ok);
    exp_q.push_back('{k + 2, 32'hC3C3_1001, 1'b0});
    check("b_frame", 32'(frame_n), 32'(k + 1));
    @(frame_ev);

    // valid on the load cycle with holding empty
    @(s31_ev);
    repeat (7) @(negedge PCLK);
    check("uf_on_load", 32'(underflow), 32'd1);
    check("ready_on_load", 32'(sample_ready), 32'd1);
    k = frame_n;
    push_pair(16'h5A5A, 16'h0F0F, ok);
    exp_q.push_back('{k + 2, 32'h5A5A_0F0F, 1'b0});
    @(frame_ev);
    @(frame_ev);

    // mute at load with holding full
    repeat (3) @(negedge PCLK);
    k = frame_n;
    mute = 1'b1;
    push_pair(16'h1234, 16'h5678, ok);
    exp_q.push_back('{k + 1, 32'h0, 1'b0});
    @(frame_ev);
    check("mute_ready", 32'(sample_ready), 32'd1);
    mute = 1'b0;

    // reset mid-frame discards holding and frame
    repeat (3) @(negedge PCLK);
    push_pair(16'hDEAD, 16'hBEEF, ok);
    check("pre_rst_ready", 32'(sample_ready), 32'd0);
    @(s20_ev);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_bck", 32'(I2S_BCK), 32'd0);
    check("mid_rst_ws", 32'(I2S_WS), 32'd0);
    check("mid_rst_data", 32'(I2S_DATA), 32'd0);
    check("mid_rst_uf", 32'(underflow), 32'd0);
    check("mid_rst_ready", 32'(sample_ready), 32'd1);
    repeat (3) @(negedge PCLK);
    #1 reset_n = 1'b1;
    @(frame_ev);
    check("rst_first_fall", 32'(cyc), 32'(BCKP));
    check("rst_frame0", 32'(frame_n), 32'd0);
    @(frame_ev);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
